// File: rtl/opu_bitplane_mac.sv
// Bit-serial 3x3 MAC: consumes one bit-plane of a 3x3 window per handshake (LSB first) and
// produces, per lane, the signed weighted sum of the unsigned pixels over one shared kernel.
module opu_bitplane_mac #(
    parameter int DW   = 128,
    parameter int BITS = 8,
    parameter int WW   = 8,
    parameter int ACCW = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DW*9-1:0]   opu_1152,
    input  logic              opu_1152_vld,
    output logic              opu_1152_rdy,
    input  logic [9*WW-1:0]   weight_in,
    input  logic              weight_load,
    output logic [DW*ACCW-1:0] res_data,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic [2:0]        plane_idx,
    output logic              busy
);

    // Nine signed weights need four guard bits for the per-plane partial sum.
    localparam int PW = WW + 4;
    localparam logic [2:0] LAST_PLANE = 3'(BITS - 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t state;
    logic signed [WW-1:0] weight_reg [9];
    logic beat;
    logic last_plane;

    assign beat       = opu_1152_vld & opu_1152_rdy;
    assign last_plane = (plane_idx == LAST_PLANE);

    // Kernel only changes while idle, so a window never mixes two kernels.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int t = 0; t < 9; t++) begin
                weight_reg[t] <= '0;
            end
        end else if (state == IDLE && weight_load) begin
            for (int t = 0; t < 9; t++) begin
                weight_reg[t] <= weight_in[(8 - t) * WW +: WW];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            opu_1152_rdy <= 1'b0;
            res_vld      <= 1'b0;
            plane_idx    <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= ACC;
                    opu_1152_rdy <= 1'b1;
                    busy         <= 1'b1;
                end
                ACC: begin
                    if (beat) begin
                        if (last_plane) begin
                            plane_idx    <= '0;
                            state        <= OUT;
                            opu_1152_rdy <= 1'b0;
                            res_vld      <= 1'b1;
                        end else begin
                            plane_idx <= plane_idx + 3'd1;
                        end
                    end
                end
                OUT: begin
                    if (res_rdy) begin
                        state   <= IDLE;
                        res_vld <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    opu_1152_rdy <= 1'b0;
                    res_vld      <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_lane
            logic signed [PW-1:0]   partial;
            logic signed [ACCW-1:0] acc_reg;
            logic signed [ACCW-1:0] acc_next;
            logic signed [ACCW-1:0] res_reg;

            always_comb begin
                partial = '0;
                for (int t = 0; t < 9; t++) begin
                    if (opu_1152[(8 - t) * DW + gi]) begin
                        partial = partial + {{(PW - WW){weight_reg[t][WW-1]}}, weight_reg[t]};
                    end
                end
            end

            // Plane p carries pixel bit weight 2^p; wraps modulo 2^ACCW by construction.
            assign acc_next = acc_reg + ({{(ACCW - PW){partial[PW-1]}}, partial} << plane_idx);

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    acc_reg <= '0;
                    res_reg <= '0;
                end else if (beat) begin
                    if (last_plane) begin
                        res_reg <= acc_next;
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= acc_next;
                    end
                end
            end

            assign res_data[gi * ACCW +: ACCW] = res_reg;
        end
    endgenerate

endmodule

// File: tb/tb_opu_bitplane_mac.sv
// Directed bench for opu_bitplane_mac: hand-computed window results, handshakes, back-pressure,
// ignored mid-window kernel loads and asynchronous reset in the middle of a window.
module tb_opu_bitplane_mac;

    localparam int DW   = 128;
    localparam int BITS = 8;
    localparam int WW   = 8;
    localparam int ACCW = 20;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic [DW*9-1:0]      opu_1152;
    logic                 opu_1152_vld;
    logic                 opu_1152_rdy;
    logic [9*WW-1:0]      weight_in;
    logic                 weight_load;
    logic [DW*ACCW-1:0]   res_data;
    logic                 res_vld;
    logic                 res_rdy;
    logic [2:0]           plane_idx;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix [9][DW];
    int         exp_lane [DW];

    opu_bitplane_mac #(.DW(DW), .BITS(BITS), .WW(WW), .ACCW(ACCW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .opu_1152     (opu_1152),
        .opu_1152_vld (opu_1152_vld),
        .opu_1152_rdy (opu_1152_rdy),
        .weight_in    (weight_in),
        .weight_load  (weight_load),
        .res_data     (res_data),
        .res_vld      (res_vld),
        .res_rdy      (res_rdy),
        .plane_idx    (plane_idx),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW*9-1:0] build_plane(input int p);
        logic [DW*9-1:0] v;
        v = '0;
        for (int t = 0; t < 9; t++)
            for (int k = 0; k < DW; k++)
                v[(8 - t) * DW + k] = pix[t][k][p];
        return v;
    endfunction

    function automatic logic [DW*ACCW-1:0] exp_vector();
        logic [DW*ACCW-1:0] v;
        for (int k = 0; k < DW; k++) v[k * ACCW +: ACCW] = exp_lane[k][ACCW-1:0];
        return v;
    endfunction

    task automatic fill_pix(input int val);
        for (int t = 0; t < 9; t++)
            for (int k = 0; k < DW; k++)
                pix[t][k] = 8'(val);
    endtask

    task automatic fill_exp(input int val);
        for (int k = 0; k < DW; k++) exp_lane[k] = val;
    endtask

    // Drives the kernel at a negedge once the block is idle; latched on the following posedge.
    task automatic load_weights(input int w [9]);
        int waited = 0;
        while (busy !== 1'b0 && waited < 100) begin
            @(negedge sys_clk);
            waited++;
        end
        chk("idle_wait", (waited < 100) ? 1 : 0, 1);
        for (int t = 0; t < 9; t++) weight_in[(8 - t) * WW +: WW] = WW'(w[t]);
        weight_load = 1'b1;
        @(negedge sys_clk);
        weight_load = 1'b0;
    endtask

    task automatic send_plane(input int p);
        int waited = 0;
        opu_1152     = build_plane(p);
        opu_1152_vld = 1'b1;
        while (opu_1152_rdy !== 1'b1 && waited < 100) begin
            @(negedge sys_clk);
            waited++;
        end
        chk("rdy_wait", (waited < 100) ? 1 : 0, 1);
        chk($sformatf("plane_idx_p%0d", p), 32'(plane_idx), p);
        @(negedge sys_clk);
        opu_1152_vld = 1'b0;
    endtask

    task automatic send_planes(input int first, input int last);
        for (int p = first; p <= last; p++) send_plane(p);
    endtask

    // Expects res_vld already high at the current negedge; completes the result handshake.
    task automatic take_result(input string tag);
        logic signed [ACCW-1:0] lv;
        chk({tag, "_res_vld"}, 32'(res_vld), 1);
        chk({tag, "_in_rdy_low"}, 32'(opu_1152_rdy), 0);
        for (int k = 0; k < DW; k++) begin
            lv = res_data[k * ACCW +: ACCW];
            chk($sformatf("%s_lane%0d", tag, k), lv, exp_lane[k]);
        end
        res_rdy = 1'b1;
        @(negedge sys_clk);
        res_rdy = 1'b0;
        chk({tag, "_res_vld_drop"}, 32'(res_vld), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        $display("window %s: lane0=%0d lane%0d=%0d", tag,
                 $signed(res_data[ACCW-1:0]), DW - 1, $signed(res_data[(DW-1)*ACCW +: ACCW]));
    endtask

    initial begin
        int w_ones [9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        int w_neg [9]   = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        int w_centre [9] = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
        int w_twos [9]  = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        int w_ramp [9]  = '{-4, -3, -2, -1, 0, 1, 2, 3, 4};
        logic [DW*ACCW-1:0] hold_exp;

        sys_rst      = 1'b1;
        opu_1152     = '0;
        opu_1152_vld = 1'b0;
        weight_in    = '0;
        weight_load  = 1'b0;
        res_rdy      = 1'b0;
        repeat (3) @(negedge sys_clk);

        chk("rst_in_rdy", 32'(opu_1152_rdy), 0);
        chk("rst_res_vld", 32'(res_vld), 0);
        chk("rst_res_data_zero", (res_data == '0) ? 1 : 0, 1);
        chk("rst_plane_idx", 32'(plane_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        sys_rst = 1'b0;

        // 1) all +1 weights, all-ones planes: 9*255
        load_weights(w_ones);
        fill_pix(255);
        fill_exp(2295);
        send_planes(0, 7);
        take_result("t1_ones");

        // 2) all -128 weights, pixels 255: sign extension at full negative range
        load_weights(w_neg);
        fill_exp(-293760);
        send_planes(0, 7);
        take_result("t2_neg");

        // 3) centre tap only, lane k pixel k; res_rdy held high in advance has no effect
        load_weights(w_centre);
        fill_pix(0);
        for (int k = 0; k < DW; k++) begin
            pix[4][k] = 8'(k % 256);
            exp_lane[k] = 3 * (k % 256);
        end
        res_rdy = 1'b1;
        send_planes(0, 7);
        chk("t3_res_vld_early", 32'(res_vld), 1);
        @(negedge sys_clk);
        res_rdy = 1'b0;
        chk("t3_one_cycle_out", 32'(res_vld), 0);
        chk("t3_idle", 32'(busy), 0);

        // 4) back-pressure: result held for 50 cycles, offered planes not taken
        send_planes(0, 7);
        hold_exp = exp_vector();
        opu_1152     = '1;
        opu_1152_vld = 1'b1;
        for (int c = 0; c < 50; c++) begin
            chk($sformatf("t4_hold_data_c%0d", c), (res_data === hold_exp) ? 1 : 0, 1);
            chk($sformatf("t4_hold_in_rdy_c%0d", c), 32'(opu_1152_rdy), 0);
            chk($sformatf("t4_hold_vld_c%0d", c), 32'(res_vld), 1);
            chk($sformatf("t4_hold_plane_c%0d", c), 32'(plane_idx), 0);
            @(negedge sys_clk);
        end
        opu_1152_vld = 1'b0;
        take_result("t4_backpressure");

        // 5) kernel load during ACC ignored; load in next IDLE applies
        load_weights(w_ones);
        fill_pix(255);
        fill_exp(2295);
        send_planes(0, 3);
        for (int t = 0; t < 9; t++) weight_in[(8 - t) * WW +: WW] = WW'(w_twos[t]);
        weight_load = 1'b1;
        @(negedge sys_clk);
        weight_load = 1'b0;
        send_planes(4, 7);
        take_result("t5_old_kernel");
        load_weights(w_twos);
        fill_exp(4590);
        send_planes(0, 7);
        take_result("t5_new_kernel");

        // 6) asynchronous reset mid-window after plane 4, then a clean window
        send_planes(0, 4);
        #2 sys_rst = 1'b1;
        #1;
        chk("t6_rst_in_rdy", 32'(opu_1152_rdy), 0);
        chk("t6_rst_res_vld", 32'(res_vld), 0);
        chk("t6_rst_plane_idx", 32'(plane_idx), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_res_data_zero", (res_data == '0) ? 1 : 0, 1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        load_weights(w_ramp);
        for (int t = 0; t < 9; t++)
            for (int k = 0; k < DW; k++)
                pix[t][k] = 8'(10 * (t + 1));
        fill_exp(600);
        send_planes(0, 7);
        take_result("t6_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
